// File: rtl/me_pkg.sv
// Shared definitions for the block-matching motion estimator: the
// controller state encoding and a constant-safe ceil(log2) used for widths.
package me_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    CMP,
    DONE
  } me_state_t;

  // Ceil(log2(value)), never below 1 so every derived bus has a real bit.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    if (result < 1) result = 1;
    return result;
  endfunction

endpackage

// File: rtl/sad_accum.sv
// Sum-of-absolute-differences accumulator: adds |a - b| to a running sum
// when enabled, clamps at all-ones, and clears on request.
module sad_accum
  import me_pkg::*;
#(
  parameter int PIXW  = 8,
  parameter int DISTW = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [PIXW-1:0]  a,
  input  logic [PIXW-1:0]  b,
  output logic [DISTW-1:0] sum
);

  // One guard bit above the wider operand holds any single-step overflow.
  localparam int SW = ((DISTW > PIXW) ? DISTW : PIXW) + 1;
  localparam logic [SW-1:0] SAT = SW'({DISTW{1'b1}});

  logic [PIXW-1:0]  diff;
  logic [SW-1:0]    total;
  logic [DISTW-1:0] next_sum;

  // Absolute difference and clamped next value of the running sum.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    diff     = (a >= b) ? (a - b) : (b - a);
    total    = SW'(sum) + SW'(diff);
    next_sum = (total > SAT) ? '1 : total[DISTW-1:0];
  end

  // Running sum register; clear wins over accumulate.
  always_ff @(posedge clk) begin
    // NOTE: state is written with non-blocking assignments so every register samples pre-edge values.
    if (reset || clr) begin
      sum <= '0;
    end else if (en) begin
      sum <= next_sum;
    end
  end

endmodule

// File: rtl/motion_estimator_param.sv
// Full-search block-matching motion estimator. Walks every candidate offset
// in raster order, streams the reference block and the shifted search block
// from two synchronous-read memories, and keeps the lowest-SAD offset.
module motion_estimator_param
  import me_pkg::*;
#(
  parameter int BLK        = 16,
  parameter int RNG        = 8,
  parameter int PIXW       = 8,
  parameter int DISTW      = 16,
  parameter int EARLY_TERM = 1
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          start,
  input  logic [PIXW-1:0]                               r_pix,
  input  logic [PIXW-1:0]                               s_pix,
  output logic [clog2(BLK*BLK)-1:0]                     addr_r,
  output logic [clog2((BLK+2*RNG)*(BLK+2*RNG))-1:0]     addr_s,
  output logic [clog2(2*RNG)-1:0]                       motion_x,
  output logic [clog2(2*RNG)-1:0]                       motion_y,
  output logic [DISTW-1:0]                              best_dist,
  output logic                                          busy,
  output logic                                          done
);

  localparam int W    = BLK + 2*RNG;
  localparam int NPIX = BLK * BLK;
  localparam int BW   = clog2(BLK);
  localparam int PW   = clog2(NPIX);
  localparam int AS_W = clog2(W*W);
  localparam int MW   = clog2(2*RNG);
  localparam logic [PW-1:0] LAST_PIX = PW'(NPIX - 1);
  localparam logic [MW-1:0] LAST_OFF = MW'(2*RNG - 1);

  me_state_t        state, state_n;
  logic [PW-1:0]    pix;        // pixel index inside the candidate, row-major
  logic [BW-1:0]    pix_row;
  logic [BW-1:0]    pix_col;
  logic [MW-1:0]    dx, dy;     // current candidate offset
  logic             in_flight;  // a read issued last cycle returns data now
  logic             aborted;    // candidate abandoned by early termination
  logic [DISTW-1:0] sad;
  logic             early_exit;
  logic             accept;
  logic             last_cand;
  logic             sad_clr;

  // BLK is a power of two, so row and column are plain bit fields.
  assign pix_row   = pix[PW-1:BW];
  assign pix_col   = pix[BW-1:0];
  assign accept    = (state == IDLE) && start;
  assign last_cand = (dx == LAST_OFF) && (dy == LAST_OFF);
  assign sad_clr   = accept || (state == CMP);
  assign busy      = (state == ISSUE) || (state == DRAIN) || (state == CMP);
  assign done      = (state == DONE);

  sad_accum #(
    .PIXW  (PIXW),
    .DISTW (DISTW)
  ) u_sad (
    .clk   (clk),
    .reset (reset),
    .clr   (sad_clr),
    .en    (in_flight),
    .a     (r_pix),
    .b     (s_pix),
    .sum   (sad)
  );

  // Controller state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic, including the early-termination exit from ISSUE.
  always_comb begin
    state_n    = state;
    early_exit = 1'b0;
    unique case (state)
      IDLE:  if (start) state_n = ISSUE;
      ISSUE: begin
        early_exit = (EARLY_TERM != 0) && (sad >= best_dist);
        if (early_exit || (pix == LAST_PIX)) state_n = DRAIN;
      end
      DRAIN: state_n = CMP;
      CMP:   state_n = last_cand ? DONE : ISSUE;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Memory addresses are driven only while issuing reads, zero otherwise.
  always_comb begin
    addr_r = '0;
    addr_s = '0;
    if (state == ISSUE) begin
      addr_r = pix;
      addr_s = AS_W'((int'(dy) + int'(pix_row)) * W + int'(dx) + int'(pix_col));
    end
  end

  // Pixel/candidate counters and the best-match registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix       <= '0;
      dx        <= '0;
      dy        <= '0;
      in_flight <= 1'b0;
      aborted   <= 1'b0;
      best_dist <= '0;
      motion_x  <= '0;
      motion_y  <= '0;
    end else begin
      in_flight <= (state == ISSUE);
      unique case (state)
        IDLE: begin
          if (start) begin
            pix       <= '0;
            dx        <= '0;
            dy        <= '0;
            aborted   <= 1'b0;
            best_dist <= '1;
            motion_x  <= '0;
            motion_y  <= '0;
          end
        end
        ISSUE: begin
          pix <= pix + PW'(1);
          if (early_exit) aborted <= 1'b1;
        end
        CMP: begin
          // Strict compare keeps the earliest candidate on ties.
          if (!aborted && (sad < best_dist)) begin
            best_dist <= sad;
            motion_x  <= dx;
            motion_y  <= dy;
          end
          aborted <= 1'b0;
          pix     <= '0;
          if (dx == LAST_OFF) begin
            dx <= '0;
            dy <= dy + MW'(1);
          end else begin
            dx <= dx + MW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/motion_estimator_param.md
MOTION_ESTIMATOR_PARAM -- requirements
Module: motion_estimator_param

Interface
REQ-001 The block SHALL have parameter BLK, default 16: reference block edge in pixels (power of two, 4..32).
REQ-002 The block SHALL have parameter RNG, default 8: search half-range; candidate offsets dx, dy run 0..2*RNG-1; window edge W = BLK+2*RNG.
REQ-003 The block SHALL have parameter PIXW, default 8: pixel width.
REQ-004 The block SHALL have parameter DISTW, default 16: distance width; SAD saturates at 2^DISTW-1.
REQ-005 The block SHALL have parameter EARLY_TERM, default 1: 1 abandons a candidate once its partial SAD >= best.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port start, input, 1 bit: starts a search when sampled high in IDLE.
REQ-009 The block SHALL have port r_pix, input, PIXW bits: reference memory read data.
REQ-010 The block SHALL have port s_pix, input, PIXW bits: search memory read data.
REQ-011 The block SHALL have port addr_r, output, clog2(BLK*BLK) bits: reference memory address.
REQ-012 The block SHALL have port addr_s, output, clog2(W*W) bits: search memory address.
REQ-013 The block SHALL have port motion_x, output, clog2(2*RNG) bits: best dx.
REQ-014 The block SHALL have port motion_y, output, clog2(2*RNG) bits: best dy.
REQ-015 The block SHALL have port best_dist, output, DISTW bits: best SAD.
REQ-016 The block SHALL have port busy, output, 1 bit: high from the cycle after start is accepted until done.
REQ-017 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-018 Both memories SHALL be treated as synchronous read: data appears on r_pix/s_pix one cycle after the address.
REQ-019 FSM states SHALL be IDLE, ISSUE, DRAIN, CMP, DONE; transitions IDLE->ISSUE on start; ISSUE->DRAIN after BLK*BLK issue cycles or on early termination; DRAIN->CMP; CMP->ISSUE if candidates remain, else CMP->DONE; DONE->IDLE.
REQ-020 Candidates SHALL be visited in raster order: dy outer, dx inner.
REQ-021 Pixels within a candidate SHALL be visited row-major (i, j) with addr_r = i*BLK+j and addr_s = (dy+i)*W+(dx+j).
REQ-022 Each candidate SHALL be accumulated as the sum of |r_pix - s_pix|, saturating at 2^DISTW-1.
REQ-023 best_dist SHALL initialise to all-ones on start; in CMP it SHALL update only if SAD < best (strictly), so the first candidate in raster order wins ties.
REQ-024 With EARLY_TERM=1, in ISSUE when partial SAD >= best, the block SHALL go to DRAIN, discard in-flight data and skip the update.
REQ-025 Each non-terminated candidate SHALL take exactly BLK*BLK+2 cycles; with start sampled at cycle 0 and EARLY_TERM=0, done SHALL be high in cycle 1+(2*RNG)^2*(BLK*BLK+2).
REQ-026 start outside IDLE SHALL be ignored, including during the DONE cycle.
REQ-027 motion_x, motion_y and best_dist SHALL hold from done until the next accepted start, and SHALL be undefined-free (registered) throughout.
REQ-028 addr_r and addr_s SHALL be 0 outside ISSUE.

Reset
REQ-029 reset SHALL put the block in IDLE with busy=0, done=0, addr_r=0, addr_s=0, motion_x=0, motion_y=0 and best_dist=0.
REQ-030 reset mid-search SHALL abort the search with no done pulse; reset SHALL take priority over start in the same cycle.

Structure
REQ-031 Package me_pkg SHALL hold the FSM state enum and the clog2 helper.
REQ-032 The SAD datapath (absolute difference plus saturating accumulate with clear) SHALL be one sub-module, sad_accum.

Verification
REQ-033 The bench SHALL cover: defaults, EARLY_TERM=0, R all 0x10, S 0x00 except block at (5,3) = 0x10 -> motion (5,3), best_dist 0, done at cycle 66049.
REQ-034 The bench SHALL cover: R and S all 0x20 -> motion (0,0), best_dist 0 (tie rule).
REQ-035 The bench SHALL cover: DISTW=8, R all 0xFF, S all 0x00 -> best_dist 255, motion (0,0).
REQ-036 The bench SHALL cover: reset at cycle 1000 of a search -> busy=0, no done pulse, outputs 0; the next start completes normally.
REQ-037 The bench SHALL cover: start pulsed during ISSUE and during DONE -> ignored, exactly one done per accepted start.
REQ-038 The bench SHALL cover: EARLY_TERM=1 with the REQ-033 data -> same result, done before cycle 66049.
